// File: rtl/spi_target.sv
// SPI mode-0 target bridging a host link to rx/tx byte streams; SPI_TARGET_RX_FIFO_EN selects a RxFifoDepth FIFO RX store, else one byte register.
// Latency: pins cross SyncStages flops; a received byte reaches rx_valid_o two cycles after the synchronized 8th SCK rise.
// Backpressure: a full RX store drops the byte (rx_overflow_o); an empty tx stream in a load slot sends 0xFF (tx_underrun_o).

`ifdef SPI_TARGET_RX_FIFO_EN
module spi_target_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_dat_o
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat_o = mem[rd_ptr_q[AW-1:0]];
endmodule
`endif

module spi_target #(
    parameter int SyncStages  = 2,
    parameter int RxFifoDepth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spi_sck_i,
    input  logic       spi_csb_i,
    input  logic       spi_sd_i,
    output logic       spi_sd_o,
    output logic       spi_sd_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       rx_overflow_o,
    output logic       tx_underrun_o
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e state_q, state_d;
    logic   enter_active, enter_idle;

    logic [SyncStages-1:0] sck_sync_q, csb_sync_q, sd_sync_q, flush_q;
    logic sck_s, csb_s, sd_s, sck_q, csb_q, armed_q;
    logic sck_rise, sck_fall, csb_fall, csb_rise;

    logic       active, shift_en, byte_done, tx_load;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q, tx_shift_q;
    logic       push_q, load_slot_q, unr_pend_q;
    logic       frame_start_q, frame_end_q, underrun_q, overflow_q;
    logic       store_full, pop, push_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0;
            csb_sync_q <= '1;
            sd_sync_q  <= '0;
            flush_q    <= '0;
            sck_q      <= 1'b0;
            csb_q      <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            csb_sync_q <= {csb_sync_q[SyncStages-2:0], spi_csb_i};
            sd_sync_q  <= {sd_sync_q[SyncStages-2:0], spi_sd_i};
            flush_q    <= {flush_q[SyncStages-2:0], 1'b1};
            sck_q      <= sck_s;
            csb_q      <= csb_s;
            // Only a CSB high seen after the chain refilled counts, so a select held through reset cannot start a frame
            armed_q    <= armed_q | (flush_q[SyncStages-1] & csb_s);
        end
    end

    assign sck_s    = sck_sync_q[SyncStages-1];
    assign csb_s    = csb_sync_q[SyncStages-1];
    assign sd_s     = sd_sync_q[SyncStages-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign csb_fall = armed_q & csb_q & ~csb_s;
    assign csb_rise = ~csb_q & csb_s;

    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        enter_idle   = 1'b0;
        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d      = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (csb_rise) begin
                    state_d    = IDLE;
                    enter_idle = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active     = (state_q == ACTIVE);
    assign shift_en   = active & ~csb_rise;
    assign byte_done  = shift_en & sck_rise & (bit_cnt_q == 3'd7);
    assign tx_ready_o = active & load_slot_q;
    assign tx_load    = tx_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            push_q        <= 1'b0;
            load_slot_q   <= 1'b0;
            unr_pend_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_start_q <= enter_active;
            frame_end_q   <= enter_idle;
            push_q        <= byte_done;
            load_slot_q   <= enter_active | byte_done;
            underrun_q    <= unr_pend_q & shift_en & sck_rise;

            if (!shift_en) begin
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                rx_shift_q <= {rx_shift_q[6:0], sd_s};
            end

            // Fall after the 8th rise is skipped: the next byte has just been loaded
            if (tx_load) begin
                tx_shift_q <= tx_valid_i ? tx_data_i : 8'hFF;
            end else if (shift_en && sck_fall && bit_cnt_q != 3'd0) begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end

            // Filler is reported once it starts going out, so a trailing boundary at frame end is not flagged
            if (!active) begin
                unr_pend_q <= 1'b0;
            end else if (tx_load) begin
                unr_pend_q <= ~tx_valid_i;
            end else if (shift_en && sck_rise) begin
                unr_pend_q <= 1'b0;
            end
        end
    end

    assign spi_sd_en_o   = active;
    assign spi_sd_o      = active & tx_shift_q[7];
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign tx_underrun_o = underrun_q;

    assign pop     = rx_valid_o & rx_ready_i;
    assign push_ok = push_q & (~store_full | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) overflow_q <= 1'b0;
        else         overflow_q <= push_q & store_full & ~pop;
    end
    assign rx_overflow_o = overflow_q;

`ifdef SPI_TARGET_RX_FIFO_EN
    logic       fifo_empty;
    logic [7:0] fifo_head;

    spi_target_fifo #(
        .Width (8),
        .Depth (RxFifoDepth)
    ) u_rx_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push_ok),
        .push_dat_i (rx_shift_q),
        .pop_i      (pop),
        .full_o     (store_full),
        .empty_o    (fifo_empty),
        .head_dat_o (fifo_head)
    );

    assign rx_valid_o = ~fifo_empty;
    assign rx_data_o  = rx_valid_o ? fifo_head : 8'h00;
`else
    logic [7:0] rx_byte_q;
    logic       rx_full_q;
    logic       unused_depth;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_byte_q <= '0;
            rx_full_q <= 1'b0;
        end else if (push_ok) begin
            rx_byte_q <= rx_shift_q;
            rx_full_q <= 1'b1;
        end else if (pop) begin
            rx_full_q <= 1'b0;
        end
    end

    assign unused_depth = ^RxFifoDepth;
    assign store_full   = rx_full_q;
    assign rx_valid_o   = rx_full_q;
    assign rx_data_o    = rx_byte_q;
`endif
endmodule
